// File: rtl/freq_sel_ctrl.sv
// rtl/freq_sel_ctrl.sv - programmable 50% duty clock divider with glitch-free ratio change
// Ratio changes and stops are deferred to the period end so no output period is cut short.
module freq_sel_ctrl #(
  parameter int CNT_W   = 8,
  parameter int DIV_RST = 5
) (
  input  logic             CLK_in,
  input  logic             RST_N,
  input  logic             EN,
  input  logic             SEL_REQ,
  input  logic [CNT_W-1:0] SEL_DIV,
  output logic             SEL_ACK,
  output logic             SEL_ERR,
  output logic             CLK_OUT,
  output logic             TICK,
  output logic             BUSY,
  output logic [CNT_W-1:0] CUR_DIV
);

  typedef enum logic [1:0] {IDLE, RUN, PEND, STOP} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cur_div_q;
  logic [CNT_W-1:0] pend_div_q;
  logic             clk_out_q;
  logic             tick_q;
  logic             ack_q;
  logic             err_q;
  logic             busy_q;

  logic wrap;
  logic period_end;
  logic req_ok;
  logic req_bad;

  assign wrap       = (cnt_q == cur_div_q - CNT_W'(1));
  // A period ends on the falling edge of CLK_OUT, i.e. the wrap out of the high phase.
  assign period_end = wrap && clk_out_q;
  assign req_ok     = SEL_REQ && (SEL_DIV != '0);
  assign req_bad    = SEL_REQ && (SEL_DIV == '0);

  always_ff @(posedge CLK_in or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cur_div_q  <= CNT_W'(DIV_RST);
      pend_div_q <= '0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      tick_q <= 1'b0;

      if (state_q != IDLE) begin
        if (wrap) begin
          cnt_q     <= '0;
          clk_out_q <= ~clk_out_q;
          tick_q    <= ~clk_out_q;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end

      case (state_q)
        IDLE: begin
          cnt_q     <= '0;
          clk_out_q <= 1'b0;
          if (req_ok) begin
            cur_div_q <= SEL_DIV;
            ack_q     <= 1'b1;
          end else if (req_bad) begin
            err_q <= 1'b1;
          end else if (EN) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (req_ok) begin
            pend_div_q <= SEL_DIV;
            busy_q     <= 1'b1;
            state_q    <= PEND;
          end else if (req_bad) begin
            err_q <= 1'b1;
          end else if (!EN) begin
            state_q <= STOP;
          end
        end
        PEND: begin
          if (period_end) begin
            cur_div_q <= pend_div_q;
            ack_q     <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= EN ? RUN : IDLE;
          end
        end
        STOP: begin
          if (period_end) begin
            state_q <= EN ? RUN : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign SEL_ACK = ack_q;
  assign SEL_ERR = err_q;
  assign CLK_OUT = clk_out_q;
  assign TICK    = tick_q;
  assign BUSY    = busy_q;
  assign CUR_DIV = cur_div_q;

endmodule

// File: tb/tb_freq_sel_ctrl.sv
// tb/tb_freq_sel_ctrl.sv - directed self-checking bench for freq_sel_ctrl
module tb_freq_sel_ctrl;

  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic             sel_req;
  logic [CNT_W-1:0] sel_div;
  logic             sel_ack;
  logic             sel_err;
  logic             clk_out;
  logic             tick;
  logic             busy;
  logic [CNT_W-1:0] cur_div;

  int total = 0;
  int bad   = 0;

  freq_sel_ctrl #(.CNT_W(CNT_W), .DIV_RST(5)) dut (
    .CLK_in  (clk),
    .RST_N   (rst_n),
    .EN      (en),
    .SEL_REQ (sel_req),
    .SEL_DIV (sel_div),
    .SEL_ACK (sel_ack),
    .SEL_ERR (sel_err),
    .CLK_OUT (clk_out),
    .TICK    (tick),
    .BUSY    (busy),
    .CUR_DIV (cur_div)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Counts negedges up to and including the one where TICK is seen, plus CLK_OUT-high samples.
  task automatic wait_tick(input string tag, output int n, output int hi);
    n  = 0;
    hi = 0;
    do begin
      @(negedge clk);
      n++;
      if (clk_out) hi++;
    end while (!tick && n < 400);
    if (!tick) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_ack(input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sel_ack && n < 400);
    if (!sel_ack) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    en      = 1'b0;
    sel_req = 1'b0;
    sel_div = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  int n, hi, acks;

  initial begin
    do_reset();
    check("rst_clk_out", clk_out, 0);
    check("rst_tick",    tick,    0);
    check("rst_ack",     sel_ack, 0);
    check("rst_err",     sel_err, 0);
    check("rst_busy",    busy,    0);
    check("rst_cur_div", cur_div, 5);

    // Default /10 operation
    en = 1'b1;
    wait_tick("first_rise", n, hi);
    check("first_rise_lat", n, 6);
    wait_tick("per5", n, hi);
    check("per5_len", n, 10);
    check("per5_hi", hi, 5);

    // Ratio change 5 -> 2 requested at the start of the high phase
    sel_req = 1'b1;
    sel_div = 8'd2;
    @(negedge clk);
    check("chg_busy", busy, 1);
    check("chg_ack_early", sel_ack, 0);
    check("chg_cur_old", cur_div, 5);
    wait_ack("chg_ack", n);
    check("chg_ack_lat", n, 4);
    check("chg_ack_fall", clk_out, 0);
    check("chg_cur_new", cur_div, 2);
    check("chg_busy_clr", busy, 0);
    sel_req = 1'b0;
    wait_tick("chg_low", n, hi);
    check("chg_low_len", n, 2);
    wait_tick("per2", n, hi);
    check("per2_len", n, 4);
    check("per2_hi", hi, 2);

    // Rejected request while running
    sel_req = 1'b1;
    sel_div = 8'd0;
    @(negedge clk);
    check("err_pulse", sel_err, 1);
    check("err_no_ack", sel_ack, 0);
    sel_req = 1'b0;
    @(negedge clk);
    check("err_one_cycle", sel_err, 0);
    check("err_cur_div", cur_div, 2);
    wait_tick("err_undisturbed", n, hi);
    check("err_undisturbed_len", n, 2);

    // Clean stop at ratio 5
    do_reset();
    en = 1'b1;
    wait_tick("stop_start", n, hi);
    hi = 1;
    @(negedge clk);
    hi++;
    en = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (clk_out) hi++;
    end while (clk_out && n < 50);
    check("stop_hi", hi, 5);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (clk_out || tick) n++;
    end
    check("stop_idle_quiet", n, 0);

    // Ratio set in IDLE; EN raised together with the request must wait a cycle
    sel_req = 1'b1;
    sel_div = 8'd50;
    en      = 1'b1;
    @(negedge clk);
    check("idle_ack", sel_ack, 1);
    check("idle_cur_div", cur_div, 50);
    check("idle_clk_out", clk_out, 0);
    sel_req = 1'b0;
    wait_tick("idle_first", n, hi);
    check("idle_first_lat", n, 51);
    wait_tick("per50", n, hi);
    check("per50_len", n, 100);
    check("per50_hi", hi, 50);

    // Reset during a pending change discards it
    sel_req = 1'b1;
    sel_div = 8'd3;
    @(negedge clk);
    check("pend_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_cur_div", cur_div, 5);
    check("arst_clk_out", clk_out, 0);
    check("arst_ack", sel_ack, 0);
    check("arst_tick", tick, 0);
    sel_req = 1'b0;
    en      = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    repeat (120) begin
      @(negedge clk);
      if (sel_ack) acks++;
    end
    check("arst_no_ack", acks, 0);
    check("arst_cur_div_hold", cur_div, 5);

    // Divide-by-2 corner
    sel_req = 1'b1;
    sel_div = 8'd1;
    en      = 1'b1;
    @(negedge clk);
    check("div1_ack", sel_ack, 1);
    sel_req = 1'b0;
    wait_tick("div1_first", n, hi);
    check("div1_first_lat", n, 2);
    wait_tick("per1", n, hi);
    check("per1_len", n, 2);
    check("per1_hi", hi, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
